// File: rtl/sc_cpu_pkg.sv
// Shared definitions for the single-cycle MIPS core: pcsource encodings,
// IFU state encodings and the default reset PC.
package sc_cpu_pkg;

  typedef enum logic [1:0] {
    PCS_SEQ = 2'b00,
    PCS_BR  = 2'b01,
    PCS_JR  = 2'b10,
    PCS_J   = 2'b11
  } pcsource_e;

  typedef enum logic [1:0] {
    IFU_IDLE,
    IFU_REQ,
    IFU_VALID,
    IFU_ERR
  } ifu_state_e;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/sc_npc_mux.sv
// Next-PC selection (sequential, branch, jr, j/jal). Purely combinational,
// shared with the datapath for jal link checks.
module sc_npc_mux
  import sc_cpu_pkg::*;
(
  input  logic [31:0] pc4,
  input  logic [31:0] inst,
  input  logic [31:0] ra,
  input  logic [1:0]  pcsource,
  output logic [31:0] next_pc
);

  logic [31:0] br_off;
  logic        unused_op;

  assign br_off    = {{14{inst[15]}}, inst[15:0], 2'b00};
  assign unused_op = &inst[31:26];

  always_comb begin
    next_pc = pc4;
    case (pcsource)
      PCS_SEQ: next_pc = pc4;
      PCS_BR:  next_pc = pc4 + br_off;
      PCS_JR:  next_pc = ra;
      PCS_J:   next_pc = {pc4[31:28], inst[25:0], 2'b00};
      default: next_pc = pc4;
    endcase
  end

endmodule

// File: rtl/sc_ifu.sv
// Instruction fetch unit: holds the PC, fetches over a req/ack bus with an
// optional timeout, and computes the next PC at commit. Macro IFU_ALIGN_CHECK_EN.
module sc_ifu
  import sc_cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [1:0]  pcsource,
  input  logic [31:0] ra,
  input  logic        commit,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
  output logic [31:0] inst,
  output logic [5:0]  op,
  output logic [5:0]  func,
  output logic [31:0] pc,
  output logic [31:0] pc4,
  output logic        inst_valid,
  output logic        bus_err
);

  // Counter only needs to reach TIMEOUT_CYC-1; the expiring cycle is decoded.
  localparam int unsigned    CW      = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);
  localparam bit             TO_EN   = (TIMEOUT_CYC != 0);
  localparam logic [CW-1:0]  TO_LAST = CW'((TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1);

  ifu_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [31:0]   pc_q, inst_q;
  logic [31:0]   next_pc, pc_load;
  logic          npc_ok;

  sc_npc_mux u_npc_mux (
    .pc4      (pc4),
    .inst     (inst_q),
    .ra       (ra),
    .pcsource (pcsource),
    .next_pc  (next_pc)
  );

`ifdef IFU_ALIGN_CHECK_EN
  assign npc_ok  = (next_pc[1:0] == 2'b00);
  assign pc_load = next_pc;
`else
  assign npc_ok  = 1'b1;
  assign pc_load = next_pc & 32'hFFFF_FFFC;
`endif

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state_q <= IFU_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IFU_IDLE:  state_d = IFU_REQ;
      IFU_REQ: begin
        // ack in the expiring cycle takes priority over the timeout
        if (imem_ack)                         state_d = IFU_VALID;
        else if (TO_EN && (cnt_q == TO_LAST)) state_d = IFU_ERR;
      end
      IFU_VALID: if (commit) state_d = npc_ok ? IFU_REQ : IFU_ERR;
      IFU_ERR:   state_d = IFU_ERR;
      default:   state_d = IFU_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      pc_q   <= RESET_PC;
      inst_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (state_q == IFU_REQ) begin
        if (imem_ack) inst_q <= imem_rdata;
        else          cnt_q  <= cnt_q + CW'(1);
      end
      if ((state_q == IFU_VALID) && commit && npc_ok) begin
        pc_q  <= pc_load;
        cnt_q <= '0;
      end
    end
  end

  assign imem_req   = (state_q == IFU_REQ);
  assign imem_addr  = pc_q;
  assign inst       = inst_q;
  assign op         = inst_q[31:26];
  assign func       = inst_q[5:0];
  assign pc         = pc_q;
  assign pc4        = pc_q + 32'd4;
  assign inst_valid = (state_q == IFU_VALID);
  assign bus_err    = (state_q == IFU_ERR);

endmodule

// File: tb/tb_sc_ifu.sv
// Scoreboard bench for sc_ifu: driver pushes expected fetch addresses and
// instructions from a reference model; a negedge monitor pops and compares.
module tb_sc_ifu;

  localparam logic [31:0] RPC = 32'h0000_0000;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic [1:0]  pcsource = '0;
  logic [31:0] ra = '0;
  logic        commit = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        imem_ack = 1'b0;
  logic [31:0] inst, pc, pc4;
  logic [5:0]  op, func;
  logic        inst_valid, bus_err;

  always #5 clock = ~clock;

  sc_ifu #(.RESET_PC(RPC), .TIMEOUT_CYC(4)) dut (
    .clock(clock), .resetn(resetn), .pcsource(pcsource), .ra(ra),
    .commit(commit), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_ack(imem_ack), .inst(inst), .op(op),
    .func(func), .pc(pc), .pc4(pc4), .inst_valid(inst_valid), .bus_err(bus_err)
  );

  typedef struct { logic [31:0] pc; logic [31:0] inst; } exp_inst_t;

  int          checks = 0, errors = 0;
  logic [31:0] exp_addr_q[$];
  exp_inst_t   exp_inst_q[$];
  logic [31:0] m_pc, m_inst;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=timeout expected=event", name);
  endtask

  // Reference next-PC from the ISA rules, in plain arithmetic.
  function automatic logic [31:0] model_npc(input logic [31:0] cur, input logic [31:0] ins,
                                            input logic [1:0] sel, input logic [31:0] rav);
    logic [31:0] seq, off;
    seq = cur + 32'd4;
    off = {{16{ins[15]}}, ins[15:0]};
    case (sel)
      2'd0: return seq;
      2'd1: return seq + off * 32'd4;
      2'd2: return rav;
      default: return (seq & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) * 32'd4);
    endcase
  endfunction

  // Monitor
  logic      req_d = 1'b0, iv_d = 1'b0;
  exp_inst_t e;
  always @(negedge clock) begin
    if (!resetn) begin
      req_d = 1'b0;
      iv_d  = 1'b0;
    end else begin
      if (imem_req && !req_d) begin
        if (exp_addr_q.size() == 0) fail_now("unexpected_fetch");
        else check32("fetch_addr", imem_addr, exp_addr_q.pop_front());
      end
      if (inst_valid && !iv_d) begin
        if (exp_inst_q.size() == 0) fail_now("unexpected_valid");
        else begin
          e = exp_inst_q.pop_front();
          check32("inst", inst, e.inst);
          check32("pc", pc, e.pc);
          check32("pc4", pc4, e.pc + 32'd4);
          check32("op", {26'd0, op}, e.inst >> 26);
          check32("func", {26'd0, func}, e.inst & 32'h3F);
        end
      end
      if (imem_req && inst_valid) check32("req_and_valid", 32'd1, 32'd0);
      req_d = imem_req;
      iv_d  = inst_valid;
    end
  end

  task automatic do_reset();
    #2;
    resetn   = 1'b0;
    imem_ack = 1'b0;
    commit   = 1'b0;
    #1;
    check32("rst_req", {31'd0, imem_req}, 32'd0);
    check32("rst_valid", {31'd0, inst_valid}, 32'd0);
    check32("rst_err", {31'd0, bus_err}, 32'd0);
    check32("rst_pc", pc, RPC);
    check32("rst_inst", inst, 32'd0);
    exp_addr_q.delete();
    exp_inst_q.delete();
    m_pc = RPC;
    exp_addr_q.push_back(RPC);
    @(negedge clock);
    resetn = 1'b1;
  endtask

  task automatic wait_sig(input bit want_req, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (want_req ? imem_req : inst_valid) begin
        ok = 1'b1;
        break;
      end
      @(negedge clock);
    end
    if (!ok) fail_now(want_req ? "wait_req" : "wait_valid");
  endtask

  task automatic do_fetch(input logic [31:0] rdata, input int unsigned lat);
    bit ok;
    wait_sig(1'b1, ok);
    if (!ok) return;
    repeat (lat) begin
      commit = 1'($urandom_range(0, 1));
      @(negedge clock);
    end
    commit     = 1'b0;
    imem_ack   = 1'b1;
    imem_rdata = rdata;
    exp_inst_q.push_back('{m_pc, rdata});
    m_inst = rdata;
    @(negedge clock);
    imem_ack   = 1'b0;
    imem_rdata = $urandom;
  endtask

  task automatic do_commit(input logic [1:0] sel, input logic [31:0] rav, input int unsigned lat);
    bit          ok, misal;
    logic [31:0] npc;
    wait_sig(1'b0, ok);
    if (!ok) return;
    repeat (lat) begin
      imem_ack   = 1'($urandom_range(0, 1));
      imem_rdata = $urandom;
      @(negedge clock);
    end
    imem_ack = 1'b0;
    commit   = 1'b1;
    pcsource = sel;
    ra       = rav;
    npc      = model_npc(m_pc, m_inst, sel, rav);
    misal    = 1'b0;
`ifdef IFU_ALIGN_CHECK_EN
    misal = (npc % 4) != 0;
`else
    npc = npc - (npc % 4);
`endif
    if (!misal) begin
      m_pc = npc;
      exp_addr_q.push_back(npc);
    end
    @(negedge clock);
    commit   = 1'b0;
    pcsource = 2'($urandom);
    ra       = $urandom;
    if (misal) begin
      check32("misal_err", {31'd0, bus_err}, 32'd1);
      check32("misal_req", {31'd0, imem_req}, 32'd0);
      check32("misal_pc", pc, m_pc);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [31:0] rv;
    @(negedge clock);
    do_reset();

    // Directed sequence
    do_fetch(32'h2008_0005, 0);
    do_commit(2'd2, 32'h0000_0010, 0);
    do_fetch(32'h1000_FFFF, 1);
    do_commit(2'd1, 32'hDEAD_BEEF, 0);
    do_fetch(32'h1000_FFFF, 2);
    do_commit(2'd0, 32'hDEAD_BEEF, 1);
    do_fetch($urandom, 0);
    do_commit(2'd2, 32'h3000_0000, 0);
    do_fetch(32'h0800_0040, 0);
    do_commit(2'd3, 32'h0, 0);
    do_fetch($urandom, 0);
    do_commit(2'd2, 32'h0000_0200, 0);
    do_fetch($urandom, 0);
    do_commit(2'd2, 32'h0000_0202, 0);
    do_reset();

    // Timeout: ack withheld for four REQ cycles
    wait_sig(1'b1, n[0]);
    n = 0;
    while (imem_req && n < 10) begin
      n++;
      @(negedge clock);
    end
    check32("timeout_cycles", n, 4);
    check32("timeout_err", {31'd0, bus_err}, 32'd1);
    check32("timeout_req", {31'd0, imem_req}, 32'd0);
    imem_ack = 1'b1;
    commit   = 1'b1;
    repeat (3) @(negedge clock);
    imem_ack = 1'b0;
    commit   = 1'b0;
    check32("err_sticky", {31'd0, bus_err}, 32'd1);
    check32("err_no_req", {31'd0, imem_req}, 32'd0);
    check32("err_no_valid", {31'd0, inst_valid}, 32'd0);
    do_reset();

    // Ack in the fourth REQ cycle wins over the timeout
    do_fetch(32'h0000_0020, 3);
    check32("late_ack_err", {31'd0, bus_err}, 32'd0);
    do_commit(2'd2, 32'h0000_0040, 0);
    check32("midreq_addr", imem_addr, 32'h0000_0040);
    do_reset();

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      do_fetch($urandom, $urandom_range(0, 3));
      rv = $urandom;
`ifdef IFU_ALIGN_CHECK_EN
      rv = rv & 32'hFFFF_FFFC;
`else
      if ($urandom_range(0, 3) != 0) rv = rv & 32'hFFFF_FFFC;
`endif
      do_commit(2'($urandom), rv, $urandom_range(0, 3));
    end
    repeat (2) @(negedge clock);
    check32("addr_q_empty", exp_addr_q.size(), 0);
    check32("inst_q_empty", exp_inst_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
